// File: rtl/clk_en_sampler.sv
// Single-clock sampler: clock-enable strobes capture a shared free-running counter
// into per-channel pending slots, arbitrated by fixed priority into a valid/ready FIFO.
module clk_en_sampler #(
  parameter int WIDTH = 2,
  parameter int NCH   = 2,
  parameter int DIVW  = 4,
  parameter int DEPTH = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NCH*DIVW-1:0]   div,
  input  logic                  load,
  output logic [WIDTH-1:0]      cnt_o,
  output logic [NCH-1:0]        stb_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CHW-1:0]        out_ch,
  output logic [NCH-1:0]        overflow,
  input  logic                  clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] cnt_q;
  logic [DIVW-1:0]  ph_q   [NCH];
  logic [DIVW-1:0]  div_q  [NCH];
  logic [NCH-1:0]   pend_v;
  logic [WIDTH-1:0] pend_d [NCH];
  logic [NCH-1:0]   ovf_q;

  logic [WIDTH-1:0] mem_d  [DEPTH];
  logic [CHW-1:0]   mem_ch [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic [CHW-1:0]   sel;
  logic             any_pend;
  logic             pop, push;
  logic [NCH-1:0]   push_oh;
  logic [NCH-1:0]   drop;

  // Strobes decode registered phase state, so captures always see the pre-edge counter.
  always_comb begin
    stb_o = '0;
    for (int unsigned c = 0; c < NCH; c++)
      stb_o[c] = en && (ph_q[c] == div_q[c]);
  end

  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (pend_v[c] && !any_pend) begin
        any_pend = 1'b1;
        sel      = CHW'(c);
      end
    end
  end

  assign pop  = out_valid && out_ready;
  assign push = any_pend && ((count != FULL) || pop);

  always_comb begin
    push_oh = '0;
    drop    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      push_oh[c] = push && (sel == CHW'(c));
      drop[c]    = stb_o[c] && pend_v[c] && !push_oh[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_v <= '0;
      ovf_q  <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        ph_q[c]   <= '0;
        div_q[c]  <= DIVW'(1);
        pend_d[c] <= '0;
      end
    end else begin
      if (en)
        cnt_q <= cnt_q + 1'b1;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (load) begin
          div_q[c] <= div[c*DIVW +: DIVW];
          ph_q[c]  <= '0;
        end else if (en) begin
          ph_q[c]  <= stb_o[c] ? '0 : ph_q[c] + 1'b1;
        end
        // A slot emptied by this edge's push can take a new capture on the same edge.
        if (stb_o[c] && !drop[c]) begin
          pend_d[c] <= cnt_q;
          pend_v[c] <= 1'b1;
        end else if (push_oh[c]) begin
          pend_v[c] <= 1'b0;
        end
      end
      ovf_q <= drop | (clr_ovf ? '0 : ovf_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr]  <= pend_d[sel];
      mem_ch[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_d[rd_ptr]  : '0;
  assign out_ch    = out_valid ? mem_ch[rd_ptr] : '0;
  assign cnt_o     = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_clk_en_sampler.sv
// Directed bench for clk_en_sampler with hand-computed expected sample streams.
module tb_clk_en_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div;
  logic       load;
  logic [1:0] cnt_o;
  logic [1:0] stb_o;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [0:0] out_ch;
  logic [1:0] overflow;
  logic       clr_ovf;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  clk_en_sampler #(.WIDTH(2), .NCH(2), .DIVW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .load(load),
    .cnt_o(cnt_o), .stb_o(stb_o), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ch, input logic [31:0] data);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"},    32'(out_ch),    ch);
    chk({tag, "_data"},  32'(out_data),  data);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) tick();
  endtask

  // Default dividers, en=1, out_ready=1: edges 1..7 after reset release.
  task automatic default_stream(input string tag);
    tick();
    chk({tag, "_e1_cnt"}, 32'(cnt_o), 32'd1);
    chk({tag, "_e1_stb"}, 32'(stb_o), 32'd3);
    chk({tag, "_e1_vld"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_e2_cnt"}, 32'(cnt_o), 32'd2);
    chk({tag, "_e2_stb"}, 32'(stb_o), 32'd0);
    chk({tag, "_e2_vld"}, 32'(out_valid), 32'd0);
    tick(); chk_head({tag, "_e3"}, 0, 1);
    tick(); chk_head({tag, "_e4"}, 1, 1);
    tick(); chk_head({tag, "_e5"}, 0, 3);
    tick(); chk_head({tag, "_e6"}, 1, 3);
    tick(); chk_head({tag, "_e7"}, 0, 1);
    chk({tag, "_e7_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; div = 8'h00; out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ch",    32'(out_ch),    32'd0);
    chk("rst_cnt",   32'(cnt_o),     32'd0);
    chk("rst_stb",   32'(stb_o),     32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);

    // Basic stream, then freeze en for 5 edges.
    rst_n = 1'b1;
    default_stream("a");
    en = 1'b0;
    #1;
    chk("a_frz_stb", 32'(stb_o), 32'd0);
    tick(); chk_head("a_e8", 1, 1);
    tick(); chk("a_e9_vld", 32'(out_valid), 32'd0);
    repeat (3) tick();
    chk("a_e12_cnt", 32'(cnt_o), 32'd3);
    chk("a_e12_stb", 32'(stb_o), 32'd0);
    chk("a_e12_vld", 32'(out_valid), 32'd0);
    en = 1'b1;
    #1;
    chk("a_resume_stb", 32'(stb_o), 32'd3);
    chk("a_resume_cnt", 32'(cnt_o), 32'd3);
    tick();
    chk("a_e13_stb", 32'(stb_o), 32'd0);
    chk("a_e13_cnt", 32'(cnt_o), 32'd0);
    tick(); chk_head("a_e14", 0, 3);
    tick(); chk_head("a_e15", 1, 3);
    chk("a_e15_ovf", 32'(overflow), 32'd0);

    // Load ch0 div=0, ch1 div=3: ch0 monopolises the arbiter.
    hold_reset();
    en = 1'b1; load = 1'b1; div = 8'h30; out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    load = 1'b0;
    chk("b_e1_stb", 32'(stb_o), 32'd1);
    chk("b_e1_cnt", 32'(cnt_o), 32'd1);
    tick();
    tick(); chk_head("b_e3", 0, 1);
    tick(); chk_head("b_e4", 0, 2);
    chk("b_e4_stb", 32'(stb_o), 32'd3);
    tick(); chk_head("b_e5", 0, 3);
    tick(); chk_head("b_e6", 0, 0);
    tick();
    tick();
    chk("b_e8_ovf", 32'(overflow), 32'd0);
    chk("b_e8_stb", 32'(stb_o), 32'd3);
    tick(); chk_head("b_e9", 0, 3);
    chk("b_e9_ovf", 32'(overflow), 32'd2);
    tick(); chk_head("b_e10", 0, 0);

    // Stall consumer for 12 edges, then drain.
    hold_reset();
    en = 1'b1; div = 8'h00; out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk_head("c_e3", 0, 1);
    repeat (3) tick();
    chk_head("c_e6", 0, 1);
    tick();
    tick();
    chk("c_e8_ovf", 32'(overflow), 32'd3);
    repeat (4) tick();
    chk_head("c_e12", 0, 1);
    chk("c_e12_ovf", 32'(overflow), 32'd3);
    out_ready = 1'b1;
    tick(); chk_head("c_e13", 1, 1);
    tick(); chk_head("c_e14", 0, 3);
    tick(); chk_head("c_e15", 1, 3);
    tick(); chk_head("c_e16", 0, 1);
    tick(); chk_head("c_e17", 1, 1);
    chk("c_e17_ovf", 32'(overflow), 32'd3);

    // clr_ovf on the same edge as a ch1 drop.
    hold_reset();
    en = 1'b1; div = 8'h00; out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (12) tick();
    chk("d_e12_ovf", 32'(overflow), 32'd3);
    load = 1'b1; div = 8'h02;
    tick();
    load = 1'b0;
    chk("d_e13_stb", 32'(stb_o), 32'd2);
    chk("d_e13_ovf", 32'(overflow), 32'd3);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("d_e14_ovf", 32'(overflow), 32'd2);

    // Asynchronous reset mid-cycle with three entries queued.
    hold_reset();
    en = 1'b1; div = 8'h00; out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    chk_head("e_e5", 0, 1);
    chk("e_e5_cnt", 32'(cnt_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_async_vld",  32'(out_valid), 32'd0);
    chk("e_async_cnt",  32'(cnt_o),     32'd0);
    chk("e_async_ovf",  32'(overflow),  32'd0);
    chk("e_async_data", 32'(out_data),  32'd0);
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    default_stream("e");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_en_sampler.md
Name: clk_en_sampler

Overview:
- Race-free replacement for derived-clock sampling: one-clock design, NCH clock-enable strobes instead of divided clocks.
- A shared WIDTH-bit free-running counter is sampled on each channel's strobe, always capturing the pre-edge counter value, so the counter update and the sample at the same edge cannot race.
- Samples pass through per-channel pending slots and a fixed-priority arbiter into a DEPTH-entry FIFO with a valid/ready output.

Parameters:
WIDTH, 2, counter and sample width
NCH, 2, number of strobe/sample channels (>=1)
DIVW, 4, width of each channel's divide value
DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  advance counter and phase counters
div  in  NCH*DIVW  per-channel divide values, channel c at [c*DIVW +: DIVW]
load  in  1  latch div into div_q and restart all phases
cnt_o  out  WIDTH  shared counter
stb_o  out  NCH  per-channel strobe, registered-state decode
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  WIDTH  sampled counter value
out_ch  out  max(1,$clog2(NCH))  channel of sample
overflow  out  NCH  sticky per-channel sample-drop flag
clr_ovf  in  1  clear all overflow bits

Behaviour:
- Clock and reset
  - Reset is asynchronous on rst_n low: cnt_q=0, all phases ph[c]=0, div_q[c]=1, pending slots empty, FIFO empty, overflow=0.
  - While in reset: out_valid=0, out_data=0, out_ch=0, cnt_o=0. stb_o decodes to 0 because ph=0 and div_q=1.
  - Reset mid-operation discards FIFO and pending contents.
- Strobe: stb_o[c] = en && (ph[c] == div_q[c]). The strobe period is div_q+1 cycles; div=0 gives a strobe every cycle.
- Each edge with en=1:
  - cnt_q <= cnt_q+1, wrapping mod 2^WIDTH.
  - ph[c] <= stb_o[c] ? 0 : ph[c]+1.
  - For each c with stb_o[c]: pend[c] <= old cnt_q, i.e. the value before this edge's increment.
- en=0: counter and phases frozen, no strobes; the FIFO keeps draining.
- load (a load edge):
  - div_q <= div and every ph <= 0. Load takes priority over the phase update on that edge.
  - cnt_q, pending slots and FIFO are unaffected.
  - A strobe active in the load cycle still captures.
- Pending slot, per channel, 1 entry:
  - If the slot is full and not being pushed this edge, a new strobe is dropped: the slot keeps its old sample and overflow[c] <= 1.
  - A slot being pushed this edge may be refilled on the same edge.
- Arbiter: each edge, the lowest-index full pending slot is pushed into the FIFO if the FIFO accepts. At most one push per edge.
- FIFO accepts when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge.
  - Pop on out_valid && out_ready.
  - out_data and out_ch are stable while out_valid && !out_ready.
  - Ordering is FIFO.
- Latency: a strobe cycle captures at edge k; the push happens at edge k+1 at the earliest; out_valid is high from edge k+1 at the earliest.
- overflow: sticky. clr_ovf clears all bits; a set on the same edge wins for that channel.
- Arithmetic: phase compare is unsigned on DIVW bits. The counter wraps silently with no flag.

Test Plan:
- Reset, then en=1, out_ready=1, no load, defaults. ch0 and ch1 strobe together on every second edge.
  - Required output sequence: (ch0,1),(ch1,1),(ch0,3),(ch1,3),(ch0,1),...
  - Captured LSB is always 1 and overflow stays 0.
- load with ch0 div=0, ch1 div=3. ch0 strobes every cycle and wins arbitration every edge.
  - ch1 pending is never pushed; overflow=2'b10 after ch1's second strobe.
  - Output is ch0 only with consecutive counter values.
- out_ready=0 for 12 cycles, defaults. FIFO fills with 4 entries, out_valid=1 with the head held stable, both pending slots fill, overflow=2'b11.
  - Then out_ready=1: the 4 entries drain in order, then the 2 pending samples, ch0 first.
- Drop en for 5 cycles mid-run. cnt_o and stb_o freeze and no new samples appear.
  - On re-enable the strobe resumes exactly div_q+1-ph cycles later, with no duplicate or skipped sample.
- Assert rst_n low asynchronously, mid-clock, with the FIFO holding 3 entries.
  - out_valid, cnt_o and overflow go to 0 immediately.
  - After release, behaviour matches the first scenario from cycle 0.
- Pulse clr_ovf on the same edge as a new ch1 drop: overflow[1] stays 1, and overflow[0] clears.
